// File: rtl/vga_sync_if.sv
// Raster timing bundle from the VGA sync generator to the monitor pins
// and to the colour stages downstream.
interface vga_sync_if;
  logic       HSYNC;
  logic       VSYNC;
  logic       video_ON;
  logic [9:0] ADDRH;
  logic [9:0] ADDRV;
  logic       PIX_TICK;
  logic       FRAME_START;

  modport master (
    output HSYNC, VSYNC, video_ON, ADDRH, ADDRV, PIX_TICK, FRAME_START
  );

  modport slave (
    input HSYNC, VSYNC, video_ON, ADDRH, ADDRV, PIX_TICK, FRAME_START
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical
// counters, and registered sync / visible-area / frame-strobe decodes.
// The decode flops load from the next counter values, so every output
// describes the coordinates shown in the same cycle.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       CLK,
  input  logic       RST,
  vga_sync_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       addrh_q, addrh_d;
  logic [9:0]       addrv_q, addrv_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             pix_tick_q, pix_tick_d;
  logic             frame_start_q, frame_start_d;

  logic pix_step;
  logic h_last;
  logic v_last;

  // Next-state for the divider and raster counters, plus decodes of the next coordinates.
  always_comb begin
    pix_step      = (div_q == DIV_LAST);
    h_last        = (addrh_q == H_LAST);
    v_last        = (addrv_q == V_LAST);
    div_d         = pix_step ? '0 : div_q + 1'b1;
    addrh_d       = addrh_q;
    addrv_d       = addrv_q;

    if (pix_step) begin
      if (h_last) begin
        // Line and frame wrap land on the same edge; no (0, V_LAST) cycle.
        addrh_d = '0;
        addrv_d = v_last ? '0 : addrv_q + 1'b1;
      end else begin
        addrh_d = addrh_q + 1'b1;
      end
    end

    // Strobe only on a genuine wrap, never on the (0,0) after reset.
    frame_start_d = pix_step && h_last && v_last;
    // Tick is high while the divider sits at its last count.
    pix_tick_d    = (div_d == DIV_LAST);
    video_on_d    = (addrh_d < H_VIS) && (addrv_d < V_VIS);
    hsync_d       = !((addrh_d >= HS_START) && (addrh_d < HS_END));
    vsync_d       = !((addrv_d >= VS_START) && (addrv_d < VS_END));
  end

  // State and output registers; reset is asynchronous and returns the raster to (0,0).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q         <= '0;
      addrh_q       <= '0;
      addrv_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      addrh_q       <= addrh_d;
      addrv_q       <= addrv_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.HSYNC       = hsync_q;
  assign vga.VSYNC       = vsync_q;
  assign vga.video_ON    = video_on_q;
  assign vga.ADDRH       = addrh_q;
  assign vga.ADDRV       = addrv_q;
  assign vga.PIX_TICK    = pix_tick_q;
  assign vga.FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a reduced raster (16x10 total, 4 clocks
// per pixel, 640 clocks per frame) so several frames fit in a short run.
// Stimulus pushes the expected outputs for each edge; the checker pops
// them on the falling edge and also measures per-frame totals.
module tb_vga_sync_gen;

  localparam int CD  = 4;
  localparam int HV  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 3;
  localparam int VV  = 6;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 1;
  localparam int HT  = HV + HFP + HS + HBP;   // 16
  localparam int VT  = VV + VFP + VS + VBP;   // 10
  localparam int FRAME_CLK = CD * HT * VT;    // 640

  // Hand-computed per-frame totals for the reduced raster.
  localparam int EXP_HS_LOW   = 120;  // 10 lines * 3 px * 4 clk
  localparam int EXP_VS_LOW   = 128;  // 2 lines * 16 px * 4 clk
  localparam int EXP_VON_CLK  = 192;  // 6 lines * 8 px * 4 clk
  localparam int EXP_VIS_TICK = 48;   // 6 * 8 visible pixels
  localparam int EXP_V1_OFS   = 64;   // one line after the frame strobe

  logic CLK = 1'b0;
  logic RST = 1'b1;

  vga_sync_if vga();

  vga_sync_gen #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .vga(vga)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic       tick;
    logic       fs;
    logic [9:0] h;
    logic [9:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   j = 0;

  // Expected outputs after j edges since reset release (j=0: reset state).
  function automatic exp_t model(int jj);
    exp_t e;
    int p, h, v;
    e = '0;
    if (jj == 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      return e;
    end
    p      = jj / CD;
    h      = p % HT;
    v      = (p / HT) % VT;
    e.h    = 10'(h);
    e.v    = 10'(v);
    e.von  = (h < HV) && (v < VV);
    e.hs   = !((h >= HV + HFP) && (h < HV + HFP + HS));
    e.vs   = !((v >= VV + VFP) && (v < VV + VFP + VS));
    e.tick = ((jj % CD) == CD - 1);
    e.fs   = ((jj % FRAME_CLK) == 0);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      if (RST) j = 0;
      else     j++;
      exp_q.push_back(model(j));
    end
  endtask

  // Stimulus: reset, two-plus frames, async reset mid-frame, four-plus frames.
  initial begin
    run_cycles(3);
    #2 RST = 1'b0;
    run_cycles(2000);
    #7 RST = 1'b1;
    run_cycles(3);
    #2 RST = 1'b0;
    run_cycles(2660);
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Checker: scoreboard pop on each falling edge, immediate check on async reset.
  initial begin
    logic rst_q;
    logic have_fs;
    logic prev_v1;
    logic v1;
    exp_t e;
    int   cyc, last_fs, hs_low, vs_low, von_clk, vis_tick, v1_rises;
    rst_q = 1'b1; have_fs = 1'b0; prev_v1 = 1'b0;
    cyc = 0; last_fs = 0; hs_low = 0; vs_low = 0; von_clk = 0; vis_tick = 0; v1_rises = 0;
    forever begin
      @(negedge CLK or posedge RST);
      if (RST && !rst_q) begin
        #1;
        chk("rst_hsync", vga.HSYNC, 1);
        chk("rst_vsync", vga.VSYNC, 1);
        chk("rst_video_on", vga.video_ON, 0);
        chk("rst_addrh", vga.ADDRH, 0);
        chk("rst_addrv", vga.ADDRV, 0);
        chk("rst_pix_tick", vga.PIX_TICK, 0);
        chk("rst_frame_start", vga.FRAME_START, 0);
        have_fs = 1'b0;
        rst_q   = 1'b1;
      end else begin
        rst_q = RST;
        cyc++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("addrh", vga.ADDRH, e.h);
          chk("addrv", vga.ADDRV, e.v);
          chk("hsync", vga.HSYNC, e.hs);
          chk("vsync", vga.VSYNC, e.vs);
          chk("video_on", vga.video_ON, e.von);
          chk("pix_tick", vga.PIX_TICK, e.tick);
          chk("frame_start", vga.FRAME_START, e.fs);
        end
        if (RST) begin
          have_fs = 1'b0;
          prev_v1 = 1'b0;
        end else begin
          if (vga.FRAME_START) begin
            if (have_fs) begin
              chk("frame_period", cyc - last_fs, FRAME_CLK);
              chk("hsync_low_clk", hs_low, EXP_HS_LOW);
              chk("vsync_low_clk", vs_low, EXP_VS_LOW);
              chk("video_on_clk", von_clk, EXP_VON_CLK);
              chk("visible_ticks", vis_tick, EXP_VIS_TICK);
              chk("addrv1_rises", v1_rises, 1);
            end
            have_fs  = 1'b1;
            last_fs  = cyc;
            hs_low   = 0;
            vs_low   = 0;
            von_clk  = 0;
            vis_tick = 0;
            v1_rises = 0;
          end
          if (!vga.HSYNC) hs_low++;
          if (!vga.VSYNC) vs_low++;
          if (vga.video_ON) von_clk++;
          if (vga.video_ON && vga.PIX_TICK) vis_tick++;
          v1 = (vga.ADDRV == 10'd1);
          if (v1 && !prev_v1) begin
            v1_rises++;
            if (have_fs) chk("addrv1_offset", cyc - last_fs, EXP_V1_OFS);
          end
          prev_v1 = v1;
        end
      end
    end
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the 640x480 @ 60 Hz VGA path. Divides the system clock into a pixel-rate tick and runs the horizontal and vertical raster counters. Drives the monitor's HSYNC/VSYNC pins and supplies the pixel coordinates, `video_ON` and a frame strobe to the colour stages downstream, such as the background gradient and overlay layers.

## Interface

**Parameters**
- `CLK_DIV`, 4: system clocks per pixel; legal range is ≥ 2 (100 MHz / 4 = 25 MHz pixel rate).
- `H_VISIBLE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

**Ports**
- `CLK` input 1: system clock.
- `RST` input 1: asynchronous, active-high reset.
- `HSYNC` output 1: horizontal sync, active-low.
- `VSYNC` output 1: vertical sync, active-low.
- `video_ON` output 1: high while (`ADDRH`, `ADDRV`) is inside the visible area.
- `ADDRH` output 10: current pixel column, 0 .. H_TOTAL-1.
- `ADDRV` output 10: current line, 0 .. V_TOTAL-1.
- `PIX_TICK` output 1: one-CLK pulse once per pixel period.
- `FRAME_START` output 1: one-CLK pulse when the raster wraps to (0,0).

## Operation

- Derived totals:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP, which is 800 with defaults.
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP, which is 525 with defaults.
- Clock divider `div`:
  - Counts 0 .. CLK_DIV-1 and wraps to 0.
  - The pixel step happens on the CLK edge where `div` wraps.
- Horizontal counter `ADDRH`:
  - Increments on each pixel step.
  - At H_TOTAL-1 it wraps to 0 and issues a line step.
- Vertical counter `ADDRV`:
  - Increments on each line step.
  - At V_TOTAL-1, coincident with a line step, it wraps to 0.
- Decodes, all evaluated on the current `ADDRH`/`ADDRV`:
  - `video_ON` = (ADDRH < H_VISIBLE) && (ADDRV < V_VISIBLE).
  - `HSYNC` = 0 iff H_VISIBLE+H_FP ≤ ADDRH < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - `VSYNC` = 0 iff V_VISIBLE+V_FP ≤ ADDRV < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
- Every output is a flop. The decode flops load from the *next* counter values, so `HSYNC`/`VSYNC`/`video_ON` always describe the `ADDRH`/`ADDRV` shown in the same cycle. There are no combinational glitches on the pins.
- All counters use unsigned arithmetic. Widths are fixed at 10 bits, so V_TOTAL and H_TOTAL must each be ≤ 1024.

## Timing

- Reset values, applied asynchronously while RST=1:
  - `div`=0, `ADDRH`=0, `ADDRV`=0.
  - `HSYNC`=1, `VSYNC`=1.
  - `video_ON`=0, `PIX_TICK`=0, `FRAME_START`=0.
- First CLK edge after RST falls:
  - `div` 0→1; the counters stay at (0,0).
  - `video_ON`→1 (decode of (0,0)). This is the only cycle in which the decode lags the counters.
- `PIX_TICK` is high during the cycle in which `div`==CLK_DIV-1. `ADDRH` advances on the edge that ends that cycle.
  - Each `ADDRH` value is held for exactly CLK_DIV clocks, including the first value after reset.
- Default periods:
  - Line: 800×4 = 3200 CLK.
  - Frame: 525 lines = 1,680,000 CLK.
  - `HSYNC` low: 384 CLK per line.
  - `VSYNC` low: 2 lines = 6400 CLK.
- `FRAME_START`:
  - High for exactly one CLK: the first cycle showing (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted for the (0,0) that follows reset.
- Line wrap and frame wrap on the same edge is the normal case at (799,524): both counters go to 0 together, with no intermediate (0,524) cycle.
- Reset mid-frame: all registers return to their reset values immediately, independent of CLK. Counting restarts from (0,0) with no FRAME_START pulse.
- `ADDRV` changes only on line wraps, so downstream edge detectors on `ADDRV` values see one rising match per frame.

## Test plan

- **Reset.** Assert RST mid-line at ADDRH=300, ADDRV=100, asynchronously between CLK edges.
  - All outputs go to their reset values before the next edge.
  - After release, ADDRH=1 appears exactly 4 CLK later.
  - No FRAME_START pulse occurs.
- **Line timing.** Run one line.
  - PIX_TICK occurs every 4 CLK.
  - ADDRH runs 0..799 and then 0.
  - HSYNC is low from ADDRH=656 through 751: 384 CLK.
  - video_ON is high for ADDRH 0..639 on visible lines: 2560 CLK.
- **Frame timing.** Run two frames.
  - FRAME_START pulses are spaced 1,680,000 CLK apart.
  - VSYNC is low for ADDRV 490..491: 6400 CLK, aligned with ADDRH=0.
  - Exactly 307,200 PIX_TICKs per frame occur with video_ON=1.
- **Wrap corner.** At (799,524), the next pixel step shows (0,0).
  - FRAME_START=1 for one CLK and video_ON=1 in that cycle.
  - No cycle shows (0,524).
- **Decode alignment.** Sample every CLK over a full frame.
  - HSYNC, VSYNC and video_ON always equal the decode of the same-cycle ADDRH/ADDRV.
  - The only exception is the first cycle after reset release.
- **Downstream hook.** Count rising transitions of (ADDRV==1) over three frames: exactly 3, each 3200 CLK after a FRAME_START.
